// File: rtl/fifo_sync_param_pkg.sv
// Shared defaults and sizing helpers for fifo_sync_param.
// Lane-buffer instances in the tx path size themselves from here.
package fifo_sync_param_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_AF_TH  = 3;
  localparam int DEF_AE_TH  = 1;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int count_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_array.sv
// FIFO storage: async clear, one write port, one async read port.
// Pointer and flag logic live in the parent.
module fifo_mem_array
  import fifo_sync_param_pkg::*;
#(
  parameter int data_width    = DEF_DATA_W,
  parameter int address_width = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [address_width-1:0] wr_addr,
  input  logic [data_width-1:0]    wr_data,
  input  logic [address_width-1:0] rd_addr,
  output logic [data_width-1:0]    rd_data
);

  localparam int DEPTH = depth_of(address_width);

  logic [data_width-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with count, almost flags, sticky errors.
// Define FIFO_RDREG_EN for a registered (1-cycle) read data path.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int data_width      = DEF_DATA_W,
  parameter int address_width   = DEF_ADDR_W,
  parameter int almost_full_th  = DEF_AF_TH,
  parameter int almost_empty_th = DEF_AE_TH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_enable,
  input  logic [data_width-1:0]  FIFO_data_in,
  input  logic                   rd_enable,
  output logic [data_width-1:0]  FIFO_data_out,
  output logic                   data_out_vld,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [address_width:0] fifo_count,
  output logic                   overflow_err,
  output logic                   underflow_err
);

  localparam int CW = count_w(address_width);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(address_width));
  localparam logic [CW-1:0] AF_C    = CW'(almost_full_th);
  localparam logic [CW-1:0] AE_C    = CW'(almost_empty_th);

  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic [CW-1:0]            count;
  logic [data_width-1:0]    rd_data;
  logic                     rd_acc;
  logic                     wr_acc;

  // Flags decode only the registered count.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign fifo_count   = count;

  // A read frees a slot, so a full FIFO may still take a write.
  assign rd_acc = rd_enable & ~empty;
  assign wr_acc = wr_enable & (~full | rd_acc);

  fifo_mem_array #(
    .data_width   (data_width),
    .address_width(address_width)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(FIFO_data_in),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_enable & full & ~rd_acc) overflow_err <= 1'b1;
      if (rd_enable & empty) underflow_err <= 1'b1;
    end
  end

`ifdef FIFO_RDREG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FIFO_data_out <= '0;
      data_out_vld  <= 1'b0;
    end else begin
      data_out_vld <= rd_acc;
      if (rd_acc) FIFO_data_out <= rd_data;
    end
  end
`else
  assign FIFO_data_out = rd_acc ? rd_data : '0;
  assign data_out_vld  = rd_acc;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed + random bench for fifo_sync_param against a queue model.
// Follows FIFO_RDREG_EN for the expected read-data timing.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_enable;
  logic [5:0] FIFO_data_in;
  logic       rd_enable;
  logic [5:0] FIFO_data_out;
  logic       data_out_vld;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] fifo_count;
  logic       overflow_err;
  logic       underflow_err;

  int nchecks = 0;
  int nerrors = 0;

  logic [5:0] q[$];
  logic       m_ovf;
  logic       m_unf;
  logic [5:0] m_last;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  always #5 clk = ~clk;

  fifo_sync_param dut (
    .clk          (clk),
    .reset        (reset),
    .wr_enable    (wr_enable),
    .FIFO_data_in (FIFO_data_in),
    .rd_enable    (rd_enable),
    .FIFO_data_out(FIFO_data_out),
    .data_out_vld (data_out_vld),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(fifo_count), 32'(n));
    chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":afull"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ":ovf"}, 32'(overflow_err), 32'(m_ovf));
    chk({tag, ":unf"}, 32'(underflow_err), 32'(m_unf));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input string tag, input logic we,
                      input logic [5:0] d, input logic re);
    logic       racc;
    logic       wacc;
    logic [5:0] exp_d;
    wr_enable    = we;
    FIFO_data_in = d;
    rd_enable    = re;
    #1;
    racc  = re && (q.size() > 0);
    wacc  = we && ((q.size() < DEPTH) || racc);
    exp_d = racc ? q[0] : 6'h00;
`ifndef FIFO_RDREG_EN
    chk({tag, ":vld"}, 32'(data_out_vld), 32'(racc));
    chk({tag, ":dout"}, 32'(FIFO_data_out), 32'(exp_d));
`endif
    if (we && !wacc) m_ovf = 1'b1;
    if (re && q.size() == 0) m_unf = 1'b1;
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back(d);
    @(posedge clk);
    #1;
`ifdef FIFO_RDREG_EN
    if (racc) m_last = exp_d;
    chk({tag, ":vld"}, 32'(data_out_vld), 32'(racc));
    chk({tag, ":dout"}, 32'(FIFO_data_out), 32'(m_last));
`endif
    check_state(tag);
    @(negedge clk);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = 6'h00;
    check_state(tag);
    chk({tag, ":dout"}, 32'(FIFO_data_out), 32'h0);
    chk({tag, ":vld"}, 32'(data_out_vld), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill4(input string tag);
    for (int i = 1; i <= 4; i++) step(tag, 1'b1, 6'(i), 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    wr_enable    = 1'b0;
    rd_enable    = 1'b0;
    FIFO_data_in = '0;
    m_ovf        = 1'b0;
    m_unf        = 1'b0;
    m_last       = '0;

    // 1: fill then drain
    do_reset("t1_rst");
    fill4("t1_wr");
    for (int i = 0; i < 4; i++) step("t1_rd", 1'b0, 6'h00, 1'b1);

    // 2: overflow while full
    do_reset("t2_rst");
    fill4("t2_wr");
    step("t2_ovf", 1'b1, 6'h3F, 1'b0);
    for (int i = 0; i < 4; i++) step("t2_rd", 1'b0, 6'h00, 1'b1);

    // 3: read+write while full
    do_reset("t3_rst");
    fill4("t3_wr");
    step("t3_rw", 1'b1, 6'h2A, 1'b1);
    for (int i = 0; i < 4; i++) step("t3_rd", 1'b0, 6'h00, 1'b1);

    // 4: read+write while empty
    do_reset("t4_rst");
    step("t4_rw", 1'b1, 6'h15, 1'b1);
    step("t4_rd", 1'b0, 6'h00, 1'b1);

    // 5: wrap-around pairs
    do_reset("t5_rst");
    for (int i = 0; i < 10; i++) begin
      step("t5_wr", 1'b1, 6'(i), 1'b0);
      step("t5_rd", 1'b0, 6'h00, 1'b1);
    end

    // random traffic
    do_reset("rnd_rst");
    for (int i = 0; i < 300; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 6'($urandom),
           1'($urandom_range(0, 1)));
    end

    // 6: reset mid-burst, no clock edge needed
    do_reset("t6_pre");
    for (int i = 0; i < 3; i++) step("t6_wr", 1'b1, 6'(i + 7), 1'b0);
    chk("t6_cnt3", 32'(fifo_count), 32'd3);
    do_reset("t6_rst");
    step("t6_unf", 1'b0, 6'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
